// File: rtl/spi_sram_23lc512.sv
`default_nettype none
// ============================================================================
// Module  : spi_sram_23lc512
// Brief   : 23LC512-compatible SPI (mode 0) serial SRAM slave, pins oversampled
//           by clock. Define SPI_HOLD_EN to add the hold_n pin.
// Revision: 1.0
// ============================================================================
module spi_sram_23lc512 #(
    parameter int         ADDR_W     = 16,
    parameter int         PAGE_BYTES = 32,
    parameter logic [7:0] MODE_RST   = 8'h40
) (
    input  logic clock,
    input  logic resetb,
    input  logic sck,
    input  logic cs_n,
    input  logic si,
`ifdef SPI_HOLD_EN
    input  logic hold_n,
`endif
    output logic so,
    output logic so_oe
);

    localparam int c_PB = $clog2(PAGE_BYTES);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_CMD  = 3'd1;
    localparam logic [2:0] S_ADDR = 3'd2;
    localparam logic [2:0] S_RD   = 3'd3;
    localparam logic [2:0] S_WR   = 3'd4;
    localparam logic [2:0] S_MRD  = 3'd5;
    localparam logic [2:0] S_MWR  = 3'd6;
    localparam logic [2:0] S_IGN  = 3'd7;

    logic [1:0]        r_sck_s, r_cs_s, r_si_s;
    logic              r_sck_d;
    logic              w_run, w_cs_hi, w_si, w_rise, w_fall, w_last8;
    logic [2:0]        r_state, w_next;
    logic [3:0]        r_bit_cnt;
    logic [14:0]       r_shift;
    logic [7:0]        w_byte_in;
    logic [15:0]       w_addr_in;
    logic [ADDR_W-1:0] r_addr, w_addr_next;
    logic [7:0]        r_mode, r_tx, r_rd_data, w_src;
    logic              r_is_rd, r_so, w_oe, w_we;
    logic [7:0]        r_mem [0:(2**ADDR_W)-1];

    always_ff @(posedge clock) begin
        if (!resetb) begin
            r_sck_s <= 2'b00;
            r_cs_s  <= 2'b11;
            r_si_s  <= 2'b00;
            r_sck_d <= 1'b0;
        end else begin
            r_sck_s <= {r_sck_s[0], sck};
            r_cs_s  <= {r_cs_s[0], cs_n};
            r_si_s  <= {r_si_s[0], si};
            r_sck_d <= r_sck_s[1];
        end
    end

`ifdef SPI_HOLD_EN
    logic [1:0] r_hold_s;
    always_ff @(posedge clock) begin
        if (!resetb) r_hold_s <= 2'b11;
        else         r_hold_s <= {r_hold_s[0], hold_n};
    end
    assign w_run = r_hold_s[1];
`else
    assign w_run = 1'b1;
`endif

    // Edges seen while held are dropped; r_sck_d keeps tracking so none is replayed.
    assign w_cs_hi   = r_cs_s[1];
    assign w_si      = r_si_s[1];
    assign w_rise    = w_run & r_sck_s[1] & ~r_sck_d;
    assign w_fall    = w_run & ~r_sck_s[1] & r_sck_d;
    assign w_last8   = (r_bit_cnt == 4'd7);
    assign w_byte_in = {r_shift[6:0], w_si};
    assign w_addr_in = {r_shift, w_si};
    assign w_src     = (r_state == S_MRD) ? r_mode : r_rd_data;

    always_comb begin
        w_addr_next = r_addr + ADDR_W'(1);
        if (r_mode[7:6] == 2'b10)
            w_addr_next = {r_addr[ADDR_W-1:c_PB], r_addr[c_PB-1:0] + c_PB'(1)};
    end

    always_ff @(posedge clock) begin
        if (!resetb) r_state <= S_IDLE;
        else         r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        if (w_cs_hi) begin
            w_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: w_next = S_CMD;
                S_CMD: if (w_rise && w_last8) begin
                    case (w_byte_in)
                        8'h03, 8'h02: w_next = S_ADDR;
                        8'h05:        w_next = S_MRD;
                        8'h01:        w_next = S_MWR;
                        default:      w_next = S_IGN;
                    endcase
                end
                S_ADDR: if (w_rise && r_bit_cnt == 4'd15) w_next = r_is_rd ? S_RD : S_WR;
                S_RD, S_WR: if (w_rise && w_last8 && r_mode[7:6] == 2'b00) w_next = S_IGN;
                S_MWR: if (w_rise && w_last8) w_next = S_IGN;
                default: w_next = r_state;
            endcase
        end
    end

    always_comb begin
        w_oe = 1'b0;
        w_we = 1'b0;
        if (!w_cs_hi && w_run && (r_state == S_RD || r_state == S_MRD)) w_oe = 1'b1;
        if (!w_cs_hi && w_rise && r_state == S_WR && w_last8) w_we = 1'b1;
    end

    always_ff @(posedge clock) begin
        if (!resetb) begin
            r_bit_cnt <= 4'd0;
            r_shift   <= 15'd0;
            r_addr    <= '0;
            r_is_rd   <= 1'b0;
            r_mode    <= MODE_RST;
            r_tx      <= 8'd0;
            r_so      <= 1'b0;
        end else if (w_cs_hi) begin
            r_bit_cnt <= 4'd0;
            r_so      <= 1'b0;
        end else begin
            if (w_rise) begin
                r_shift <= {r_shift[13:0], w_si};
                case (r_state)
                    S_CMD: begin
                        r_bit_cnt <= w_last8 ? 4'd0 : r_bit_cnt + 4'd1;
                        if (w_last8) r_is_rd <= (w_byte_in == 8'h03);
                    end
                    S_ADDR: begin
                        r_bit_cnt <= r_bit_cnt + 4'd1;
                        if (r_bit_cnt == 4'd15) r_addr <= w_addr_in[ADDR_W-1:0];
                    end
                    S_RD, S_WR, S_MRD: begin
                        r_bit_cnt <= w_last8 ? 4'd0 : r_bit_cnt + 4'd1;
                        if (w_last8 && r_state != S_MRD) r_addr <= w_addr_next;
                    end
                    S_MWR: begin
                        r_bit_cnt <= w_last8 ? 4'd0 : r_bit_cnt + 4'd1;
                        if (w_last8) r_mode <= w_byte_in;
                    end
                    default: r_bit_cnt <= r_bit_cnt;
                endcase
            end
            // Bit count 0 at a fall means a new byte starts: load it fresh.
            if (w_fall && (r_state == S_RD || r_state == S_MRD)) begin
                if (r_bit_cnt == 4'd0) begin
                    r_so <= w_src[7];
                    r_tx <= {w_src[6:0], 1'b0};
                end else begin
                    r_so <= r_tx[7];
                    r_tx <= {r_tx[6:0], 1'b0};
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (w_we) r_mem[r_addr] <= w_byte_in;
        r_rd_data <= r_mem[r_addr];
    end

    assign so    = r_so;
    assign so_oe = w_oe;

endmodule
`default_nettype wire

// File: tb/tb_spi_sram_23lc512.sv
`default_nettype none
// Testbench for spi_sram_23lc512: SPI master tasks against a byte-array model.
module tb_spi_sram_23lc512;

    localparam int HALF = 50;

    logic clock  = 1'b0;
    logic resetb = 1'b0;
    logic sck    = 1'b0;
    logic cs_n   = 1'b1;
    logic si     = 1'b0;
    logic so, so_oe;
`ifdef SPI_HOLD_EN
    logic hold_n = 1'b1;
`endif

    int         n_checks = 0;
    int         n_err    = 0;
    logic [7:0] model_mem [int];
    logic [7:0] model_mode = 8'h40;
    logic       saw_oe, all_oe;

    spi_sram_23lc512 dut (
        .clock (clock),
        .resetb(resetb),
        .sck   (sck),
        .cs_n  (cs_n),
        .si    (si),
`ifdef SPI_HOLD_EN
        .hold_n(hold_n),
`endif
        .so    (so),
        .so_oe (so_oe)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Shift n bits of tx (tx[n-1] first); so captured on each sck rise into rx.
    task automatic spi_bits(input logic [7:0] tx, input int n, output logic [7:0] rx);
        rx = 8'h00;
        for (int i = n - 1; i >= 0; i--) begin
            si = tx[i];
            #HALF;
            sck = 1'b1;
            rx[i] = so;
            if (so_oe === 1'b1) saw_oe = 1'b1;
            else                all_oe = 1'b0;
            #HALF;
            sck = 1'b0;
        end
    endtask

    function automatic int adv(input int a);
        if (model_mode[7:6] == 2'b10) return (a & 32'hFFE0) | ((a + 1) & 32'h1F);
        return (a + 1) & 32'hFFFF;
    endfunction

    task automatic cmd_addr(input logic [7:0] cmd, input logic [15:0] addr);
        logic [7:0] rx;
        cs_n = 1'b0;
        #HALF;
        spi_bits(cmd, 8, rx);
        spi_bits(addr[15:8], 8, rx);
        spi_bits(addr[7:0], 8, rx);
    endtask

    task automatic cs_end();
        #HALF;
        cs_n = 1'b1;
        #100;
    endtask

    task automatic write_txn(input logic [15:0] addr, input logic [7:0] d[$]);
        logic [7:0] rx;
        int a;
        cmd_addr(8'h02, addr);
        a = int'(addr);
        foreach (d[i]) begin
            spi_bits(d[i], 8, rx);
            if (i == 0 || model_mode[7:6] != 2'b00) model_mem[a] = d[i];
            a = adv(a);
        end
        cs_end();
    endtask

    task automatic read_txn(input logic [15:0] addr, input int n, input string tag,
                            output logic [7:0] q[$]);
        logic [7:0] rx;
        int a;
        q.delete();
        cmd_addr(8'h03, addr);
        all_oe = 1'b1;
        a = int'(addr);
        for (int i = 0; i < n; i++) begin
            spi_bits(8'h00, 8, rx);
            q.push_back(rx);
            if ((i == 0 || model_mode[7:6] != 2'b00) && model_mem.exists(a))
                chk($sformatf("%s_b%0d", tag, i), rx, model_mem[a]);
            a = adv(a);
        end
        if (n == 1 || model_mode[7:6] != 2'b00) chk({tag, "_oe"}, all_oe, 1);
        cs_end();
        chk({tag, "_oe_off"}, so_oe, 0);
    endtask

    task automatic wrmr_txn(input logic [7:0] m);
        logic [7:0] rx;
        cs_n = 1'b0;
        #HALF;
        spi_bits(8'h01, 8, rx);
        spi_bits(m, 8, rx);
        cs_end();
        model_mode = m;
    endtask

    task automatic rdmr_txn(input int n, input string tag);
        logic [7:0] rx;
        cs_n = 1'b0;
        #HALF;
        spi_bits(8'h05, 8, rx);
        for (int i = 0; i < n; i++) begin
            spi_bits(8'h00, 8, rx);
            chk($sformatf("%s_b%0d", tag, i), rx, model_mode);
        end
        cs_end();
    endtask

    initial begin
        logic [7:0] q[$];
        logic [7:0] wq[$];
        logic [7:0] rx, hi, lo;

        #3;
        resetb = 1'b0;
        #40;
        chk("rst_so", so, 0);
        chk("rst_oe", so_oe, 0);
        resetb = 1'b1;
        #20;
        rdmr_txn(1, "rdmr_rst");

        // Basic write / read back in sequential mode
        wq = {8'hA5, 8'h5A};
        write_txn(16'h1234, wq);
        read_txn(16'h1234, 2, "rd1234", q);
        chk("rd1234_lit0", q[0], 8'hA5);
        chk("rd1234_lit1", q[1], 8'h5A);

        // Page mode wraps inside the 32-byte page
        wrmr_txn(8'h80);
        wq = {8'h11, 8'h22, 8'h33};
        write_txn(16'h003E, wq);
        read_txn(16'h0020, 1, "pg0020", q);
        chk("pg0020_lit", q[0], 8'h33);
        read_txn(16'h003F, 1, "pg003F", q);
        chk("pg003F_lit", q[0], 8'h22);

        // Sequential wrap at top of array
        wrmr_txn(8'h40);
        wq = {8'hC3, 8'h3C};
        write_txn(16'hFFFF, wq);
        read_txn(16'h0000, 1, "sq0000", q);
        chk("sq0000_lit", q[0], 8'h3C);
        read_txn(16'hFFFF, 2, "sqFFFF", q);
        chk("sqFFFF_lit0", q[0], 8'hC3);
        chk("sqFFFF_lit1", q[1], 8'h3C);

        // Byte mode: only the first data byte is written
        wq = {8'hEE, 8'hDD};
        write_txn(16'h0100, wq);
        wrmr_txn(8'h00);
        rdmr_txn(3, "rdmr_byte");
        wq = {8'h77, 8'h88};
        write_txn(16'h0100, wq);
        read_txn(16'h0101, 1, "by0101", q);
        chk("by0101_lit", q[0], 8'hDD);
        read_txn(16'h0100, 1, "by0100", q);
        chk("by0100_lit", q[0], 8'h77);

        // Partial byte aborted by cs_n is discarded
        wrmr_txn(8'h40);
        wq = {8'h5C};
        write_txn(16'h0200, wq);
        cmd_addr(8'h02, 16'h0200);
        spi_bits(8'h1F, 5, rx);
        cs_end();
        read_txn(16'h0200, 1, "part0200", q);
        chk("part0200_lit", q[0], 8'h5C);

        // Unknown command never drives so
        saw_oe = 1'b0;
        cs_n = 1'b0;
        #HALF;
        spi_bits(8'h9F, 8, rx);
        spi_bits(8'hFF, 8, rx);
        spi_bits(8'h00, 8, rx);
        cs_end();
        chk("cmd9F_oe", saw_oe, 0);

        // Randomized mode / address / length traffic
        for (int k = 0; k < 8; k++) begin
            logic [7:0]  m;
            logic [15:0] a;
            int          n;
            m = 8'($urandom);
            wrmr_txn(m);
            rdmr_txn(2, $sformatf("rdmr_rnd%0d", k));
            a = 16'($urandom);
            n = $urandom_range(1, 4);
            wq.delete();
            for (int j = 0; j < n; j++) wq.push_back(8'($urandom));
            write_txn(a, wq);
            read_txn(a, n, $sformatf("rnd%0d", k), q);
        end

`ifdef SPI_HOLD_EN
        // Hold mid-byte: stray sck edges are ignored, transfer resumes intact
        wrmr_txn(8'h40);
        cmd_addr(8'h03, 16'h1234);
        spi_bits(8'h00, 4, hi);
        #HALF;
        hold_n = 1'b0;
        #100;
        chk("hold_oe", so_oe, 0);
        for (int p = 0; p < 2; p++) begin
            sck = 1'b1; #HALF; sck = 1'b0; #HALF;
        end
        hold_n = 1'b1;
        #HALF;
        spi_bits(8'h00, 4, lo);
        rx = {hi[3:0], lo[3:0]};
        chk("hold_b0", rx, 8'hA5);
        spi_bits(8'h00, 8, rx);
        chk("hold_b1", rx, 8'h5A);
        cs_end();
`endif

        // Reset in the middle of a read
        wrmr_txn(8'h80);
        cmd_addr(8'h03, 16'h1234);
        spi_bits(8'h00, 3, rx);
        resetb = 1'b0;
        #30;
        chk("midrst_so", so, 0);
        chk("midrst_oe", so_oe, 0);
        resetb = 1'b1;
        #20;
        cs_n = 1'b1;
        #100;
        model_mode = 8'h40;
        rdmr_txn(1, "rdmr_after_rst");

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
